// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memory-op and FSM encodings,
// byte-lane select constants, widths, and lane/replication helpers.
package mem_lsu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Half and word selects ignore the low offset bits, so an unchecked misaligned
    // access degrades to the surrounding aligned access.
    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        logic [3:0] sel;
        sel = 4'b0000;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                case (off)
                    2'd0:    sel = SEL_B0;
                    2'd1:    sel = SEL_B1;
                    2'd2:    sel = SEL_B2;
                    default: sel = SEL_B3;
                endcase
            end
            OP_LH, OP_LHU, OP_SH: sel = off[1] ? SEL_H1 : SEL_H0;
            OP_LW, OP_SW:         sel = SEL_W;
            default:              sel = 4'b0000;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] data);
        logic [31:0] res;
        case (op)
            OP_SB:   res = {4{data[7:0]}};
            OP_SH:   res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load-data aligner: picks the addressed byte/half/word out of the bus read data
// and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [3:0]  memop,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (off)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (memop)
            OP_LB:   result = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  result = {24'd0, byte_lane};
            OP_LH:   result = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  result = {16'd0, half_lane};
            OP_LW:   result = rdata;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes non-memory ops through and runs a stalling req/ack
// bus transaction for loads/stores. Optional misalignment trap: LSU_ALIGN_CHECK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    mem_wd_i,
    input  logic          mem_wreg_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic [3:0]    mem_memop_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_sdata_i,
    input  logic          flush_i,
    output logic          dbus_req_o,
    output logic          dbus_we_o,
    output logic [AW-1:0] dbus_addr_o,
    output logic [3:0]    dbus_sel_o,
    output logic [DW-1:0] dbus_wdata_o,
    input  logic          dbus_ack_i,
    input  logic [DW-1:0] dbus_rdata_i,
    output logic [4:0]    wb_wd_o,
    output logic          wb_wreg_o,
    output logic [DW-1:0] wb_wdata_o,
    output logic          stall_req_o,
    output logic          align_exc_o
);

    state_e      state;
    state_e      state_nxt;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic        kill_q;
    logic [31:0] load_buf;
    logic [31:0] load_ext;
    logic        is_mem;
    logic        misalign;
    logic        issue;

    assign is_mem = is_load(mem_memop_i) || is_store(mem_memop_i);

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign    = misaligned(mem_memop_i, mem_addr_i[1:0]);
    assign align_exc_o = (state == S_IDLE) && is_mem && misalign && !flush_i;
`else
    assign misalign    = 1'b0;
    assign align_exc_o = 1'b0;
`endif

    assign issue = (state == S_IDLE) && is_mem && !misalign && !flush_i;

    // Op and offset are latched at issue so a flush that clears EX/MEM mid-transaction
    // cannot change how the returning data is interpreted.
    lsu_load_align u_align (
        .rdata  (dbus_rdata_i),
        .off    (off_q),
        .memop  (op_q),
        .result (load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue) state_nxt = S_WAIT;
            S_WAIT:  if (dbus_ack_i) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_sel_o   <= 4'b0000;
            dbus_wdata_o <= '0;
            op_q         <= OP_NONE;
            off_q        <= 2'b00;
            kill_q       <= 1'b0;
            load_buf     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_store(mem_memop_i);
                        dbus_addr_o  <= {mem_addr_i[AW-1:2], 2'b00};
                        dbus_sel_o   <= lane_sel(mem_memop_i, mem_addr_i[1:0]);
                        dbus_wdata_o <= store_data(mem_memop_i, mem_sdata_i);
                        op_q         <= mem_memop_i;
                        off_q        <= mem_addr_i[1:0];
                        kill_q       <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (flush_i) kill_q <= 1'b1;
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        if (is_load(op_q)) load_buf <= load_ext;
                    end
                end
                S_DONE: kill_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Any stalled cycle presents a bubble to MEM/WB; a flushed transaction never writes back.
    always_comb begin
        wb_wd_o     = 5'd0;
        wb_wreg_o   = 1'b0;
        wb_wdata_o  = '0;
        stall_req_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    stall_req_o = 1'b1;
                end else if (!flush_i && !is_mem) begin
                    wb_wd_o    = mem_wd_i;
                    wb_wreg_o  = mem_wreg_i;
                    wb_wdata_o = mem_wdata_i;
                end
            end
            S_WAIT: stall_req_o = 1'b1;
            S_DONE: begin
                wb_wd_o = mem_wd_i;
                if (is_load(op_q)) begin
                    wb_wreg_o  = mem_wreg_i && !kill_q;
                    wb_wdata_o = load_buf;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Non-memory instructions pass straight through combinationally.
- Loads and stores run a multi-cycle req/ack transaction on the data bus. The unit stalls the pipeline until the result is ready.
- Forms load write-back data with byte-lane extraction and sign/zero extension.

Parameters:
- DW, 32, data bus width (fixed 32; lane logic assumes 4 bytes).
- AW, 32, data bus address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_wd_i  in  5  destination register from EX/MEM
- mem_wreg_i  in  1  write-enable from EX/MEM
- mem_wdata_i  in  32  ALU result from EX/MEM
- mem_memop_i  in  4  memory op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others treated as NONE
- mem_addr_i  in  32  effective address
- mem_sdata_i  in  32  store data (rt)
- flush_i  in  1  pipeline flush
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_sel_o  out  4  byte enables
- dbus_wdata_o  out  32  store data, lane-replicated
- dbus_ack_i  in  1  one-cycle completion strobe
- dbus_rdata_i  in  32  read data, valid with ack
- wb_wd_o  out  5  destination register to MEM/WB
- wb_wreg_o  out  1  write-enable to MEM/WB
- wb_wdata_o  out  32  write-back data to MEM/WB
- stall_req_o  out  1  stall request to pipeline control
- align_exc_o  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset is rst, synchronous, active-high. Clock is clk.
- On reset:
  - State goes to IDLE.
  - dbus_req_o=0, dbus_we_o=0, dbus_sel_o=0, dbus_addr_o=0, dbus_wdata_o=0.
  - Load buffer clears to 0. stall_req_o=0.
- Reset mid-transaction abandons the bus cycle. A late ack arriving while in IDLE is ignored.
- Little-endian lanes:
  - Byte select: addr[1:0]=0→0001, 1→0010, 2→0100, 3→1000.
  - Half select: addr[1]=0→0011, addr[1]=1→1100.
  - Word select: 1111.
- Store data replication:
  - SB: {4{sdata[7:0]}}
  - SH: {2{sdata[15:0]}}
  - SW: sdata unchanged.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - memop NONE: wb_* = mem_*_i combinationally, stall_req_o=0.
  - Load or store op and flush_i=0: stall_req_o=1. Register dbus_req_o=1 with we/addr/sel/wdata, then go to WAIT.
- WAIT:
  - stall_req_o=1. Bus outputs are held stable until ack.
  - On dbus_ack_i: dbus_req_o←0. For loads, capture the extracted and extended rdata into the load buffer. Go to DONE.
- DONE:
  - stall_req_o=0. The next state is always IDLE, which prevents re-issue while the EX/MEM inputs are still held.
  - Load: wb_wdata_o = load buffer, wb_wreg_o = mem_wreg_i.
  - Store: wb_wreg_o=0.
- Minimum memory-op latency is 3 cycles (IDLE, WAIT with same-cycle ack, DONE). Each extra wait cycle adds 1.
- Load extension:
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH: sign-extend the selected half. LHU: zero-extend it.
  - LW: whole word.
- Whenever the unit is stalled (IDLE-issue cycle, WAIT): wb_wreg_o=0, wb_wdata_o=0, wb_wd_o=0.
- flush_i:
  - In IDLE: suppresses issue. Outputs are zero.
  - In WAIT: the bus cycle completes, but the result is discarded. A sticky kill flag forces wb_wreg_o=0 in DONE.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Any of these is misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned op issues no bus request and does not stall.
  - align_exc_o=1 for that cycle and wb_wreg_o=0.
- Undefined:
  - align_exc_o is tied to 0.
  - For half ops, addr[0] is ignored. For word ops, addr[1:0] are ignored. The access completes as an aligned access.

Decomposition:
- Shared defines/package (lsu_defs): memop encodings, FSM state encodings, byte-select constants, the width macros already used by the pipeline registers.
- One sub-module, lsu_load_align: combinational. Inputs are rdata, addr[1:0] and memop; output is the extended 32-bit result. Instantiated once.

Test Plan:
- memop=NONE, wdata=0x1234_5678, wd=5, wreg=1 → same-cycle wb outputs equal the inputs; stall_req_o=0; no dbus_req_o.
- LW addr=0x100, ack 2 cycles after req, rdata=0xDEAD_BEEF → stall high for 3 cycles; dbus_sel_o=1111; DONE gives wb_wdata_o=0xDEAD_BEEF.
- LB addr=0x103, rdata=0x80FF_0000 → sel=1000; wb_wdata_o=0xFFFF_FF80. Same access with LBU → 0x0000_0080.
- SH addr=0x102, sdata=0x0000_ABCD → dbus_we_o=1, sel=1100, wdata=0xABCD_ABCD; DONE has wb_wreg_o=0.
- LW with flush_i pulsed during WAIT, then ack → bus cycle completes; DONE has wb_wreg_o=0; FSM returns to IDLE.
- LSU_ALIGN_CHECK_EN defined, LW addr=0x102 → align_exc_o=1, no req, stall_req_o=0. Undefined → aligned read of 0x100 completes.
